// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared definitions for the MIPS32 CP0 register file:
//               register indices, exception codes and register layouts.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register indices served by the register file
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    // Exception codes reported in Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    // Status register layout (only BEV, IM, EXL, IE are implemented)
    typedef struct packed {
        logic [8:0] rsvd_hi;   // 31:23
        logic       bev;       // 22
        logic [5:0] rsvd_mid;  // 21:16
        logic [7:0] im;        // 15:8
        logic [5:0] rsvd_lo;   // 7:2
        logic       exl;       // 1
        logic       ie;        // 0
    } status_t;

    // Cause register layout
    typedef struct packed {
        logic        bd;       // 31
        logic        ti;       // 30
        logic [13:0] rsvd_hi;  // 29:16
        logic [7:0]  ip;       // 15:8
        logic        rsvd_7;   // 7
        logic [4:0]  exc_code; // 6:2
        logic [1:0]  rsvd_lo;  // 1:0
    } cause_t;

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Prescaled Count/Compare timer with timer-interrupt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int              PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          w_tick;
    logic [31:0]   w_count_inc;

    assign w_tick      = (presc_q == PRESC_LAST);
    assign w_count_inc = count_q + 32'd1;

    // Next-state: prescaler wrap advances Count; Compare write beats a match
    always_comb begin
        presc_d   = w_tick ? '0 : presc_q + PW'(1);
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = wr_data_i;
            presc_d = '0;
        end else if (w_tick) begin
            count_d = w_count_inc;
        end
        if (compare_we_i) begin
            compare_d = wr_data_i;
            ti_d      = 1'b0;
        end else if (!count_we_i && w_tick && (w_count_inc == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile
// Description : Parametrised MIPS32 CP0 register file: exception/ERET/MTC0
//               handling, synchronised interrupts, Count/Compare timer.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int          NUM_EXT_INT = 6,
    parameter int          COUNT_DIV   = 2,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] PRID        = 32'h0000_4220
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_EXT_INT-1:0] ext_int,
    input  logic                   wr_en,
    input  logic [4:0]             wr_idx,
    input  logic [31:0]            wr_data,
    input  logic [4:0]             rd_idx,
    output logic [31:0]            rd_data,
    input  logic                   exc_valid,
    input  logic [4:0]             exc_code,
    input  logic [31:0]            exc_pc,
    input  logic                   exc_bd,
    input  logic                   exc_badaddr_valid,
    input  logic [31:0]            exc_badaddr,
    input  logic                   eret,
    output logic [31:0]            epc,
    output logic                   status_exl,
    output logic                   int_req
);

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ipsw_q, ipsw_d;

    logic                   w_wr_act;
    logic [NUM_EXT_INT-1:0] w_ext_sync;
    logic [5:0]             w_hw;
    logic [7:0]             w_ip;
    logic [31:0]            w_count, w_compare;
    logic                   w_ti;
    status_t                w_status;
    cause_t                 w_cause;

    // MTC0 only lands when no exception or ERET commits this cycle
    assign w_wr_act = wr_en & ~exc_valid & ~eret;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (w_wr_act && (wr_idx == CP0_COUNT)),
        .compare_we_i (w_wr_act && (wr_idx == CP0_COMPARE)),
        .wr_data_i    (wr_data),
        .count_o      (w_count),
        .compare_o    (w_compare),
        .ti_o         (w_ti)
    );

    // Per-line synchroniser chain for the asynchronous interrupt inputs
    for (genvar i = 0; i < NUM_EXT_INT; i++) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        if (SYNC_STAGES == 1) begin : g_one
            // Single sampling flop
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) sync_q <= '0;
                else         sync_q <= ext_int[i];
            end
        end else begin : g_chain
            // Shift the line through the chain, oldest sample at the MSB
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) sync_q <= '0;
                else         sync_q <= {sync_q[SYNC_STAGES-2:0], ext_int[i]};
            end
        end
        assign w_ext_sync[i] = sync_q[SYNC_STAGES-1];
    end

    // Zero-pad the hardware lines to the full six IP positions
    for (genvar j = 0; j < 6; j++) begin : g_hw
        if (j < NUM_EXT_INT) begin : g_line
            assign w_hw[j] = w_ext_sync[j];
        end else begin : g_pad
            assign w_hw[j] = 1'b0;
        end
    end

    assign w_ip = {w_ti | w_hw[5], w_hw[4:0], ipsw_q};

    // Event resolution: exception beats ERET beats MTC0
    always_comb begin
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ipsw_d     = ipsw_q;
        if (exc_valid) begin
            // Nested exceptions keep the original return address and BD
            if (!exl_q) begin
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_bd;
                exl_d = 1'b1;
            end
            exccode_d = exc_code;
            if (exc_badaddr_valid) badvaddr_d = exc_badaddr;
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (wr_en) begin
            case (wr_idx)
                CP0_BADVADDR: badvaddr_d = wr_data;
                CP0_STATUS: begin
                    im_d  = wr_data[15:8];
                    exl_d = wr_data[1];
                    ie_d  = wr_data[0];
                end
                CP0_CAUSE:    ipsw_d = wr_data[9:8];
                CP0_EPC:      epc_d  = wr_data;
                default:      ;
            endcase
        end
    end

    // Architectural CP0 state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ipsw_q     <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ipsw_q     <= ipsw_d;
        end
    end

    // Assemble the architectural views of Status and Cause
    always_comb begin
        w_status          = '0;
        w_status.bev      = 1'b1;
        w_status.im       = im_q;
        w_status.exl      = exl_q;
        w_status.ie       = ie_q;
        w_cause           = '0;
        w_cause.bd        = bd_q;
        w_cause.ti        = w_ti;
        w_cause.ip        = w_ip;
        w_cause.exc_code  = exccode_q;
    end

    // MFC0 read mux; unimplemented indices read zero
    always_comb begin
        rd_data = '0;
        case (rd_idx)
            CP0_BADVADDR: rd_data = badvaddr_q;
            CP0_COUNT:    rd_data = w_count;
            CP0_COMPARE:  rd_data = w_compare;
            CP0_STATUS:   rd_data = w_status;
            CP0_CAUSE:    rd_data = w_cause;
            CP0_EPC:      rd_data = epc_q;
            CP0_PRID:     rd_data = PRID;
            default:      rd_data = '0;
        endcase
    end

    assign epc        = epc_q;
    assign status_exl = exl_q;
    assign int_req    = ie_q & ~exl_q & (|(w_ip & im_q));

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_regfile
// Description : Self-checking bench for cp0_regfile (directed table,
//               hand-written corner sequences, randomized model compare).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile;

    localparam int NEI = 2;
    localparam int DIV = 2;
    localparam int SS  = 2;

    logic           clk = 1'b0;
    logic           resetn;
    logic [NEI-1:0] ext_int;
    logic           wr_en;
    logic [4:0]     wr_idx;
    logic [31:0]    wr_data;
    logic [4:0]     rd_idx;
    logic [31:0]    rd_data;
    logic           exc_valid;
    logic [4:0]     exc_code;
    logic [31:0]    exc_pc;
    logic           exc_bd;
    logic           exc_badaddr_valid;
    logic [31:0]    exc_badaddr;
    logic           eret;
    logic [31:0]    epc;
    logic           status_exl;
    logic           int_req;

    always #5 clk = ~clk;

    cp0_regfile #(
        .NUM_EXT_INT (NEI),
        .COUNT_DIV   (DIV),
        .SYNC_STAGES (SS),
        .PRID        (32'h0000_4220)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ext_int           (ext_int),
        .wr_en             (wr_en),
        .wr_idx            (wr_idx),
        .wr_data           (wr_data),
        .rd_idx            (rd_idx),
        .rd_data           (rd_data),
        .exc_valid         (exc_valid),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_bd            (exc_bd),
        .exc_badaddr_valid (exc_badaddr_valid),
        .exc_badaddr       (exc_badaddr),
        .eret              (eret),
        .epc               (epc),
        .status_exl        (status_exl),
        .int_req           (int_req)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (architectural view) ----------------
    logic [31:0]    m_badv, m_compare, m_epc, m_load;
    int             m_cyc;       // cycles since reset or last Count load
    logic [7:0]     m_im;
    logic           m_exl, m_ie, m_bd, m_ti;
    logic [4:0]     m_exccode;
    logic [1:0]     m_ipsw;
    logic [NEI-1:0] m_hist[$];   // ext_int samples still travelling the synchroniser

    function automatic logic [31:0] m_count();
        return m_load + 32'(m_cyc / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        logic [NEI-1:0] s;
        s = m_hist[0];
        return {m_ti, 3'b000, s[1], s[0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13:   return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_exccode, 2'b0};
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4220;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_intreq();
        return m_ie & ~m_exl & (|(m_ip() & m_im));
    endfunction

    task automatic model_reset();
        m_badv = '0; m_compare = '0; m_epc = '0; m_load = '0; m_cyc = 0;
        m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
        m_exccode = '0; m_ipsw = '0;
        m_hist.delete();
        for (int k = 0; k < SS; k++) m_hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [31:0] old_cnt, new_cnt;
        logic        cnt_w, cmp_w;
        old_cnt = m_count();
        cnt_w   = 1'b0;
        cmp_w   = 1'b0;
        if (exc_valid) begin
            if (!m_exl) begin
                m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                m_bd  = exc_bd;
                m_exl = 1'b1;
            end
            m_exccode = exc_code;
            if (exc_badaddr_valid) m_badv = exc_badaddr;
        end else if (eret) begin
            m_exl = 1'b0;
        end else if (wr_en) begin
            case (wr_idx)
                5'd8:  m_badv = wr_data;
                5'd9:  cnt_w = 1'b1;
                5'd11: cmp_w = 1'b1;
                5'd12: begin m_im = wr_data[15:8]; m_exl = wr_data[1]; m_ie = wr_data[0]; end
                5'd13: m_ipsw = wr_data[9:8];
                5'd14: m_epc = wr_data;
                default: ;
            endcase
        end
        if (cnt_w) begin
            m_load = wr_data;
            m_cyc  = 0;
        end else begin
            m_cyc++;
        end
        new_cnt = m_count();
        if (cmp_w) begin
            m_ti      = 1'b0;
            m_compare = wr_data;
        end else if (!cnt_w && new_cnt != old_cnt && new_cnt == m_compare) begin
            m_ti = 1'b1;
        end
        m_hist.push_back(ext_int);
        void'(m_hist.pop_front());
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge, then compare every output against the model
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_rd_data", rd_data, m_read(rd_idx));
        chk("model_epc", epc, m_epc);
        chk("model_status_exl", {31'b0, status_exl}, {31'b0, m_exl});
        chk("model_int_req", {31'b0, int_req}, {31'b0, m_intreq()});
    endtask

    task automatic clear_events();
        wr_en = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_badaddr_valid = 1'b0;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Mid-cycle asynchronous reset pulse; called just after tick()
    task automatic reset_pulse();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        rd_idx = 5'd12;
        #0;
        chk("rst_status", rd_data, 32'h0040_0000);
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_exl", {31'b0, status_exl}, 32'h0);
        rd_idx = 5'd9;
        #1;
        chk("rst_count", rd_data, 32'h0);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic [4:0]  ridx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0040_0000};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd8,  32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         5'd14, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd15, 32'h0000_4220};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd3,  32'h0};
        vecs[5]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
        vecs[6]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        vecs[7]  = '{1'b1, 5'd15, 32'hFFFF_FFFF, 5'd15, 32'h0000_4220};
        vecs[8]  = '{1'b1, 5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0};
        vecs[9]  = '{1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
        vecs[10] = '{1'b1, 5'd8,  32'hCAFE_F00D, 5'd8,  32'hCAFE_F00D};
        vecs[11] = '{1'b1, 5'd12, 32'h0,         5'd12, 32'h0040_0000};
        vecs[12] = '{1'b1, 5'd13, 32'h0,         5'd13, 32'h0};

        resetn = 1'b0; ext_int = '0; wr_idx = '0; wr_data = '0; rd_idx = 5'd12;
        exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badaddr = '0;
        clear_events();
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Table: reset values and write masks
        reset_pulse();
        foreach (vecs[i]) begin
            wr_en = vecs[i].we; wr_idx = vecs[i].widx; wr_data = vecs[i].wdata;
            rd_idx = vecs[i].ridx;
            tick();
            wr_en = 1'b0;
            chk($sformatf("vec%0d", i), rd_data, vecs[i].exp);
        end

        // Timer: Compare=5 written on the first edge after reset
        reset_pulse();
        rd_idx = 5'd13;
        wr(5'd11, 32'd5);
        repeat (8) tick();
        chk("ti_early", rd_data, 32'h0);
        tick();
        chk("ti_cause", rd_data, 32'h4000_8000);
        rd_idx = 5'd9;
        #1 chk("ti_count", rd_data, 32'd5);
        rd_idx = 5'd13;
        wr(5'd12, 32'h0000_8001);
        chk("ti_int_req", {31'b0, int_req}, 32'h1);
        wr(5'd11, 32'd5);
        chk("ti_clear", rd_data, 32'h0);
        chk("ti_int_clear", {31'b0, int_req}, 32'h0);

        // Delay-slot exception, then a nested one
        reset_pulse();
        rd_idx = 5'd13;
        exc_valid = 1'b1; exc_pc = 32'hBFC0_0104; exc_bd = 1'b1; exc_code = 5'h0C;
        exc_badaddr_valid = 1'b1; exc_badaddr = 32'hDEAD_BEEF;
        tick();
        clear_events();
        chk("ds_epc", epc, 32'hBFC0_0100);
        chk("ds_cause", rd_data, 32'h8000_0030);
        chk("ds_exl", {31'b0, status_exl}, 32'h1);
        rd_idx = 5'd8;
        #1 chk("ds_badvaddr", rd_data, 32'hDEAD_BEEF);
        rd_idx = 5'd13;
        exc_valid = 1'b1; exc_pc = 32'h0000_0100; exc_bd = 1'b0; exc_code = 5'h04;
        tick();
        clear_events();
        chk("nest_epc", epc, 32'hBFC0_0100);
        chk("nest_cause", rd_data, 32'h8000_0010);

        // Priority: exception, ERET and MTC0 all in one cycle
        reset_pulse();
        wr(5'd12, 32'h0000_FF01);
        rd_idx = 5'd12;
        exc_valid = 1'b1; exc_pc = 32'h0000_0080; exc_bd = 1'b0; exc_code = 5'h08;
        eret = 1'b1; wr_en = 1'b1; wr_idx = 5'd12; wr_data = 32'h0;
        tick();
        clear_events();
        chk("prio_status", rd_data, 32'h0040_FF03);
        chk("prio_epc", epc, 32'h0000_0080);
        chk("prio_exl", {31'b0, status_exl}, 32'h1);

        // External interrupt latency, masking by EXL, release by ERET
        reset_pulse();
        rd_idx = 5'd13;
        wr(5'd12, 32'h0000_0C01);
        ext_int = 2'b10;
        tick();
        chk("ext_lat1", {31'b0, int_req}, 32'h0);
        tick();
        chk("ext_lat2", {31'b0, int_req}, 32'h1);
        exc_valid = 1'b1; exc_pc = 32'h0000_0200; exc_bd = 1'b0; exc_code = 5'h00;
        tick();
        clear_events();
        chk("ext_exl_mask", {31'b0, int_req}, 32'h0);
        eret = 1'b1;
        tick();
        clear_events();
        chk("ext_eret", {31'b0, int_req}, 32'h1);
        ext_int = 2'b00;
        tick();
        chk("ext_fall1", {31'b0, int_req}, 32'h1);
        tick();
        chk("ext_fall2", {31'b0, int_req}, 32'h0);
        reset_pulse();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) reset_pulse();
            exc_valid         = ($urandom_range(0, 99) < 6);
            eret              = ($urandom_range(0, 15) == 0);
            wr_en             = ($urandom_range(0, 3) == 0);
            exc_pc            = $urandom;
            exc_bd            = 1'($urandom);
            exc_code          = 5'($urandom);
            exc_badaddr_valid = 1'($urandom);
            exc_badaddr       = $urandom;
            wr_data           = $urandom;
            case ($urandom_range(0, 8))
                0: wr_idx = 5'd8;
                1: begin
                    wr_idx = 5'd9;
                    if ($urandom_range(0, 1) == 1) wr_data = 32'hFFFF_FFFF - $urandom_range(0, 3);
                end
                2, 3: begin
                    wr_idx = 5'd11;
                    if ($urandom_range(0, 3) != 0) wr_data = m_count() + $urandom_range(0, 6);
                end
                4: wr_idx = 5'd12;
                5: wr_idx = 5'd13;
                6: wr_idx = 5'd14;
                7: wr_idx = 5'd15;
                default: wr_idx = 5'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) ext_int = NEI'($urandom);
            rd_idx = 5'($urandom);
            tick();
        end
        clear_events();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
